reg_bank_3p: RTL and testbench



---
 rtl/reg_bank_pkg.sv | 11 +
 rtl/reg_bank_3p.sv | 57 +++++
 tb/tb_reg_bank_3p.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/reg_bank_pkg.sv
// Shared sizing constants and types for the three-port register bank.
package reg_bank_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/reg_bank_3p.sv
// Three-port register bank: one synchronous write port, two combinational read ports.
// Reset is asynchronous and active-low and clears every register.
// Optional build macro REG_BANK_ZERO_REG_EN: when defined, register 0 is hardwired to zero
// (writes to address 0 are dropped and reads of address 0 return 0).
module reg_bank_3p
    import reg_bank_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we3,
    input  logic [ADDR_W-1:0] wa3,
    input  logic [DATA_W-1:0] wd3,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    data_t [NUM_REGS-1:0] regs_q;
    data_t [NUM_REGS-1:0] regs_d;
    logic                 wr_en;

`ifdef REG_BANK_ZERO_REG_EN
    assign wr_en = we3 && (wa3 != '0);
`else
    assign wr_en = we3;
`endif

    // Write decoder: only the addressed register takes new data, others hold.
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wa3] = wd3;
        end
    end

    // Storage update; reset wins over any write at the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read muxes straight off the stored array; no write-to-read bypass.
    always_comb begin
`ifdef REG_BANK_ZERO_REG_EN
        rd1 = (ra1 == '0) ? '0 : regs_q[ra1];
        rd2 = (ra2 == '0) ? '0 : regs_q[ra2];
`else
        rd1 = regs_q[ra1];
        rd2 = regs_q[ra2];
`endif
    end

endmodule

// File: tb/tb_reg_bank_3p.sv
// Scoreboard bench for reg_bank_3p: stimulus pushes expected read data, a monitor
// pops and compares on each sample strobe.
module tb_reg_bank_3p;
    import reg_bank_pkg::*;

    logic  clk;
    logic  reset;
    logic  we3;
    addr_t wa3;
    data_t wd3;
    addr_t ra1;
    addr_t ra2;
    data_t rd1;
    data_t rd2;

    reg_bank_3p u_dut (
        .clk   (clk),
        .reset (reset),
        .we3   (we3),
        .wa3   (wa3),
        .wd3   (wd3),
        .ra1   (ra1),
        .ra2   (ra2),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    // Clock held low until after the initial reset pulse.
    initial begin
        clk = 1'b0;
        #20;
        forever #5 clk = ~clk;
    end

    int unsigned  checks;
    int unsigned  errors;
    logic [15:0]  exp_q[$];
    string        name_q[$];
    logic         smp;
    bit           done;

    // Expected contents after the sequential fill.
    function automatic data_t fill_val(input int k);
`ifdef REG_BANK_ZERO_REG_EN
        if (k == 0) return '0;
`endif
        return data_t'(20 * (k + 1));
    endfunction

    // Queue an expectation, then strobe the monitor after inputs settle.
    task automatic expect_rd(input data_t e1, input data_t e2, input string nm);
        exp_q.push_back({e1, e2});
        name_q.push_back(nm);
        #1 smp = 1'b1;
        #1 smp = 1'b0;
    endtask

    task automatic set_rd(input int a1, input int a2);
        ra1 = addr_t'(a1);
        ra2 = addr_t'(a2);
    endtask

    // Monitor: pop one expectation per strobe and compare both read ports.
    initial begin
        forever begin
            @(posedge smp);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: got rd1=%0h rd2=%0h with no expectation", rd1, rd2);
            end else begin
                logic [15:0] e;
                string       nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if ({rd1, rd2} !== e) begin
                    errors++;
                    $display("FAIL %s: got rd1=%0h rd2=%0h, expected rd1=%0h rd2=%0h",
                             nm, rd1, rd2, e[15:8], e[7:0]);
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        if (!done) begin
            $display("FAIL watchdog: got no completion, expected end of stimulus");
            $fatal(1, "timeout");
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        smp    = 1'b0;
        done   = 1'b0;
        reset  = 1'b1;
        we3    = 1'b0;
        wa3    = '0;
        wd3    = '0;
        ra1    = '0;
        ra2    = '0;

        // Reset pulse before any clock edge.
        #1 reset = 1'b0;
        #5 reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            set_rd(k, 7 - k);
            expect_rd(8'h00, 8'h00, $sformatf("reset_rd_%0d", k));
            #3;
        end

        // Sequential fill: each address sees two writes, the later one sticks.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            we3 = 1'b1;
            wa3 = addr_t'(i / 2);
            wd3 = data_t'(10 * (i + 1));
        end
        @(negedge clk);
        we3 = 1'b0;

        // Dual read of pairs.
        for (int p = 0; p < 4; p++) begin
            set_rd(2 * p, 2 * p + 1);
            expect_rd(fill_val(2 * p), fill_val(2 * p + 1), $sformatf("dual_rd_%0d", p));
        end
        set_rd(3, 3);
        expect_rd(8'd80, 8'd80, "same_addr");
        // Change addresses with no intervening clock edge.
        set_rd(7, 0);
        expect_rd(8'd160, fill_val(0), "midcycle_ra");

        // Write disable: address and data move, nothing is stored.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            we3 = 1'b0;
            wa3 = addr_t'(i);
            wd3 = data_t'(8'h55 + i);
        end
        @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            set_rd(2 * p, 2 * p + 1);
            expect_rd(fill_val(2 * p), fill_val(2 * p + 1), $sformatf("we_off_%0d", p));
        end

        // Read-during-write: old value before the edge, new value after.
        @(negedge clk);
        set_rd(5, 4);
        we3 = 1'b1;
        wa3 = 3'd5;
        wd3 = 8'hAA;
        expect_rd(8'd120, 8'd100, "rdw_before");
        @(posedge clk);
        expect_rd(8'hAA, 8'd100, "rdw_after");
        @(negedge clk);
        we3 = 1'b0;
        wd3 = 8'h00;

        // Reset mid-operation, entirely between two rising edges.
        set_rd(7, 5);
        expect_rd(8'd160, 8'hAA, "pre_reset");
        @(posedge clk);
        #2 reset = 1'b0;
        expect_rd(8'h00, 8'h00, "reset_async");
        #3 reset = 1'b1;
        for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            set_rd(2 * p, 2 * p + 1);
            expect_rd(8'h00, 8'h00, $sformatf("post_reset_%0d", p));
        end

        // First write after reset lands on the next qualifying edge.
        @(negedge clk);
        we3 = 1'b1;
        wa3 = 3'd2;
        wd3 = 8'h3C;
        set_rd(2, 2);
        expect_rd(8'h00, 8'h00, "first_wr_before");
        @(posedge clk);
        expect_rd(8'h3C, 8'h3C, "first_wr_after");
        @(negedge clk);
        we3 = 1'b0;

        #5;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
